// File: rtl/laser_cover_eval.sv
// rtl/laser_cover_eval.sv - two-circle laser placement coverage scorer with ping-pong point capture
module laser_cover_eval #(
    parameter int N_PTS     = 40,
    parameter int RADIUS_SQ = 16,
    parameter int CNT_W     = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [3:0]       X,
    input  logic [3:0]       Y,
    input  logic             DONE_IN,
    input  logic [3:0]       C1X,
    input  logic [3:0]       C1Y,
    input  logic [3:0]       C2X,
    input  logic [3:0]       C2Y,
    output logic             RPT_VALID,
    output logic [CNT_W-1:0] C1_CNT,
    output logic [CNT_W-1:0] C2_CNT,
    output logic [CNT_W-1:0] UNION_CNT,
    output logic [CNT_W-1:0] PTS_CNT,
    output logic             ERR,
    output logic             DROP,
    output logic             BUSY
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(N_PTS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Two frame banks; each entry packs {x, y}.
    logic [7:0]       mem_q [2][N_PTS];
    logic             cap_bank_q;
    logic             eval_bank_q;
    logic [CNT_W-1:0] cap_idx_q;
    logic [CNT_W-1:0] eval_idx_q;
    logic [CNT_W-1:0] eval_len_q;
    logic [3:0]       c1x_q, c1y_q, c2x_q, c2y_q;
    logic [CNT_W-1:0] acc1_q, acc2_q, accu_q;

    logic             rpt_valid_q;
    logic [CNT_W-1:0] c1_cnt_q, c2_cnt_q, union_cnt_q, pts_cnt_q;
    logic             err_q, drop_q, busy_q;

    logic             cap_wr;
    logic             done_acc;
    logic [CNT_W-1:0] frame_len;
    logic [7:0]       eval_pt;
    logic             hit1, hit2;
    logic             last_pt;

    // Absolute differences keep the distance unsigned so no wrap can fake a near point.
    function automatic logic covered(input logic [3:0] cx, input logic [3:0] cy,
                                     input logic [3:0] px, input logic [3:0] py);
        logic [3:0] dx, dy;
        logic [8:0] dx9, dy9, sum;
        dx  = (cx > px) ? (cx - px) : (px - cx);
        dy  = (cy > py) ? (cy - py) : (py - cy);
        dx9 = {5'd0, dx};
        dy9 = {5'd0, dy};
        sum = dx9 * dx9 + dy9 * dy9;
        return (sum <= 9'(RADIUS_SQ));
    endfunction

    // Capture and evaluation strobes; a point arriving with DONE still counts toward the closing frame.
    always_comb begin
        cap_wr    = IN_VALID && (cap_idx_q < FULL);
        done_acc  = DONE_IN && (state_q == S_IDLE);
        frame_len = cap_idx_q + CNT_W'(cap_wr);
        eval_pt   = mem_q[eval_bank_q][eval_idx_q];
        hit1      = covered(c1x_q, c1y_q, eval_pt[7:4], eval_pt[3:0]);
        hit2      = covered(c2x_q, c2y_q, eval_pt[7:4], eval_pt[3:0]);
        last_pt   = ((eval_idx_q + CNT_W'(1)) == eval_len_q);
    end

    // Next-state logic; an empty frame skips straight to its report.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (done_acc) begin
                    state_d = (frame_len == '0) ? S_REPORT : S_EVAL;
                end
            end
            S_EVAL: begin
                if (last_pt) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Point storage write port; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (cap_wr) begin
            mem_q[cap_bank_q][cap_idx_q] <= {X, Y};
        end
    end

    // Control, capture indexing, accumulation and report registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cap_bank_q  <= 1'b0;
            eval_bank_q <= 1'b0;
            cap_idx_q   <= '0;
            eval_idx_q  <= '0;
            eval_len_q  <= '0;
            c1x_q       <= '0;
            c1y_q       <= '0;
            c2x_q       <= '0;
            c2y_q       <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            accu_q      <= '0;
            rpt_valid_q <= 1'b0;
            c1_cnt_q    <= '0;
            c2_cnt_q    <= '0;
            union_cnt_q <= '0;
            pts_cnt_q   <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            drop_q      <= DONE_IN && (state_q != S_IDLE);
            rpt_valid_q <= (state_q == S_REPORT);

            if (done_acc) begin
                cap_idx_q  <= '0;
                cap_bank_q <= ~cap_bank_q;
            end else if (cap_wr) begin
                cap_idx_q  <= cap_idx_q + CNT_W'(1);
            end

            if (done_acc) begin
                c1x_q       <= C1X;
                c1y_q       <= C1Y;
                c2x_q       <= C2X;
                c2y_q       <= C2Y;
                eval_len_q  <= frame_len;
                eval_bank_q <= cap_bank_q;
                eval_idx_q  <= '0;
                acc1_q      <= '0;
                acc2_q      <= '0;
                accu_q      <= '0;
            end else if (state_q == S_EVAL) begin
                acc1_q     <= acc1_q + CNT_W'(hit1);
                acc2_q     <= acc2_q + CNT_W'(hit2);
                accu_q     <= accu_q + CNT_W'(hit1 | hit2);
                eval_idx_q <= eval_idx_q + CNT_W'(1);
            end

            if (state_q == S_REPORT) begin
                c1_cnt_q    <= acc1_q;
                c2_cnt_q    <= acc2_q;
                union_cnt_q <= accu_q;
                pts_cnt_q   <= eval_len_q;
                err_q       <= (eval_len_q != FULL);
            end
        end
    end

    assign RPT_VALID = rpt_valid_q;
    assign C1_CNT    = c1_cnt_q;
    assign C2_CNT    = c2_cnt_q;
    assign UNION_CNT = union_cnt_q;
    assign PTS_CNT   = pts_cnt_q;
    assign ERR       = err_q;
    assign DROP      = drop_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_laser_cover_eval.sv
// tb/tb_laser_cover_eval.sv - scoreboard bench for laser_cover_eval
module tb_laser_cover_eval;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic [3:0] X = '0, Y = '0;
    logic       DONE_IN = 1'b0;
    logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
    logic       RPT_VALID, ERR, DROP, BUSY;
    logic [5:0] C1_CNT, C2_CNT, UNION_CNT, PTS_CNT;

    laser_cover_eval dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y),
        .DONE_IN(DONE_IN), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .RPT_VALID(RPT_VALID), .C1_CNT(C1_CNT), .C2_CNT(C2_CNT),
        .UNION_CNT(UNION_CNT), .PTS_CNT(PTS_CNT), .ERR(ERR),
        .DROP(DROP), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int c1;
        int c2;
        int un;
        int pts;
        int err;
        int cyc;
    } exp_t;

    exp_t rq[$];
    int   dq[$];
    int   px[$];
    int   py[$];
    int   cyc = 0;
    int   busy_end = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int covers(input int cx, input int cy, input int qx, input int qy);
        int dx, dy;
        dx = cx - qx;
        dy = cy - qy;
        return (dx * dx + dy * dy <= 16) ? 1 : 0;
    endfunction

    // Monitor: pop expected reports and drops as the DUT produces them.
    always @(negedge CLK) begin
        exp_t e;
        int   dc;
        if (RPT_VALID === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected_rpt", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                chk("rpt_cycle", cyc, e.cyc);
                chk("c1_cnt", 32'(C1_CNT), e.c1);
                chk("c2_cnt", 32'(C2_CNT), e.c2);
                chk("union_cnt", 32'(UNION_CNT), e.un);
                chk("pts_cnt", 32'(PTS_CNT), e.pts);
                chk("err", 32'(ERR), e.err);
            end
        end
        if (DROP === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_drop", 32'd1, 32'd0);
            end else begin
                dc = dq.pop_front();
                chk("drop_cycle", cyc, dc);
            end
        end
    end

    task automatic put(input int x, input int y);
        @(negedge CLK);
        IN_VALID = 1'b1;
        X = 4'(x);
        Y = 4'(y);
        DONE_IN = 1'b0;
        if (px.size() < 40) begin
            px.push_back(x);
            py.push_back(y);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            IN_VALID = 1'b0;
            DONE_IN = 1'b0;
        end
    endtask

    task automatic do_done(input int c1x, input int c1y, input int c2x, input int c2y);
        exp_t e;
        int   ec;
        bit   acc;
        int   a, b;
        @(negedge CLK);
        ec = cyc + 1;
        IN_VALID = 1'b0;
        DONE_IN = 1'b1;
        C1X = 4'(c1x);
        C1Y = 4'(c1y);
        C2X = 4'(c2x);
        C2Y = 4'(c2y);
        acc = (ec > busy_end);
        if (acc) begin
            e.c1 = 0;
            e.c2 = 0;
            e.un = 0;
            foreach (px[i]) begin
                a = covers(c1x, c1y, px[i], py[i]);
                b = covers(c2x, c2y, px[i], py[i]);
                e.c1 += a;
                e.c2 += b;
                e.un += (a + b > 0) ? 1 : 0;
            end
            e.pts = px.size();
            e.err = (px.size() != 40) ? 1 : 0;
            e.cyc = ec + px.size() + 1;
            busy_end = e.cyc;
            rq.push_back(e);
            px.delete();
            py.delete();
        end else begin
            dq.push_back(ec);
        end
        @(negedge CLK);
        DONE_IN = 1'b0;
        if (acc) chk("busy_after_done", 32'(BUSY), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        IN_VALID = 1'b0;
        DONE_IN = 1'b0;
        @(negedge CLK);
        rq.delete();
        dq.delete();
        px.delete();
        py.delete();
        busy_end = 0;
        chk("rst_rpt_valid", 32'(RPT_VALID), 32'd0);
        chk("rst_c1", 32'(C1_CNT), 32'd0);
        chk("rst_c2", 32'(C2_CNT), 32'd0);
        chk("rst_union", 32'(UNION_CNT), 32'd0);
        chk("rst_pts", 32'(PTS_CNT), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_drop", 32'(DROP), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
    endtask

    initial begin
        do_reset();
        idle(2);

        // Full frame at one spot, circle 1 centred on it.
        repeat (40) put(5, 5);
        do_done(5, 5, 0, 0);
        idle(45);

        // Radius boundary: sum 16 covered, sum 17 not.
        put(9, 5);
        put(9, 6);
        repeat (38) put(15, 15);
        do_done(5, 5, 15, 15);
        idle(45);

        // Overlapping circles, then a second circle just out of reach.
        repeat (40) put(4, 4);
        do_done(4, 4, 6, 6);
        idle(45);
        repeat (40) put(4, 4);
        do_done(4, 4, 8, 8);
        idle(45);

        // Short frame, then long frame with saturation.
        repeat (39) put(7, 3);
        do_done(7, 3, 0, 0);
        idle(45);
        for (int i = 0; i < 45; i++) put(i % 16, (i * 3) % 16);
        do_done(2, 6, 12, 9);
        idle(45);

        // Frame B streams during A's evaluation; a DONE 10 cycles in is dropped.
        for (int i = 0; i < 40; i++) put($urandom_range(0, 15), $urandom_range(0, 15));
        do_done(6, 7, 10, 4);
        repeat (8) put($urandom_range(0, 15), $urandom_range(0, 15));
        do_done(1, 1, 1, 1);
        repeat (32) put($urandom_range(0, 15), $urandom_range(0, 15));
        idle(40);
        do_done(9, 9, 3, 12);
        idle(45);

        // Reset mid-evaluation abandons the report; next frame scores normally.
        repeat (40) put(5, 5);
        do_done(5, 5, 5, 5);
        idle(18);
        do_reset();
        for (int i = 0; i < 40; i++) put($urandom_range(0, 15), $urandom_range(0, 15));
        do_done(8, 8, 4, 11);
        idle(45);

        chk("rpt_queue_empty", rq.size(), 32'd0);
        chk("drop_queue_empty", dq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/laser_cover_eval.md
Name: laser_cover_eval

Overview:
- Downstream checker for the two-circle laser placement engine.
- Snoops the same 40-point X/Y stream the engine consumes and stores each frame in a ping-pong buffer.
- On the engine's DONE pulse, latches C1/C2 and scores the placement by counting points covered by circle 1, circle 2 and their union (radius 4, boundary inclusive).
- Results feed the host/scoreboard. Evaluation of one frame overlaps capture of the next.

Parameters:
- N_PTS, 40, points per frame.
- RADIUS_SQ, 16, squared radius; a point is covered when dx²+dy² <= RADIUS_SQ.
- CNT_W, 6, count width; must satisfy 2^CNT_W > N_PTS.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  X/Y carry a point this cycle.
- X  in  4  point x.
- Y  in  4  point y.
- DONE_IN  in  1  engine DONE; one-cycle pulse; C1X..C2Y are valid in the same cycle.
- C1X, C1Y, C2X, C2Y  in  4 each  engine circle centres.
- RPT_VALID  out  1  one-cycle pulse; report outputs updated this cycle.
- C1_CNT  out  CNT_W  points covered by circle 1.
- C2_CNT  out  CNT_W  points covered by circle 2.
- UNION_CNT  out  CNT_W  points covered by either circle.
- PTS_CNT  out  CNT_W  points evaluated in the reported frame.
- ERR  out  1  reported frame had PTS_CNT != N_PTS.
- DROP  out  1  one-cycle pulse; DONE_IN ignored because an evaluation was in progress.
- BUSY  out  1  high in EVAL/REPORT.

Behaviour:
- Reset (RST=1 at a rising edge):
  - All outputs go to 0.
  - State goes to IDLE; capture bank = 0; capture index = 0.
  - Any evaluation in progress is abandoned; no RPT_VALID follows.
- Storage: two banks of N_PTS x {x[3:0], y[3:0]}.
- Capture, in every state:
  - IN_VALID=1 with index < N_PTS: write the point to capture bank[index], then index+1.
  - IN_VALID=1 with index == N_PTS: point discarded; index saturates.
- States: IDLE, EVAL, REPORT.
- IDLE:
  - DONE_IN=1: latch C1X..C2Y and eval_len = capture index; swap banks (eval bank = old capture bank); capture index <- 0; clear accumulators; go to EVAL.
  - If IN_VALID=1 in the same cycle as the accepted DONE_IN, the point belongs to the finished frame. It is written at the old index, and only if that index < N_PTS.
- EVAL:
  - One point per cycle, eval index 0..eval_len-1.
  - Each cycle: c1 = inside(C1, p), c2 = inside(C2, p).
  - C1 acc += c1; C2 acc += c2; union acc += (c1 | c2).
  - After the last index, go to REPORT.
  - eval_len = 0: go directly to REPORT next cycle.
- inside():
  - dx = |Cx - x| and dy = |Cy - y|, 4-bit unsigned; no signed wrap.
  - sum = dx² + dy², 9-bit.
  - Covered when sum <= RADIUS_SQ.
- REPORT, one cycle:
  - Register accumulators into C1_CNT, C2_CNT, UNION_CNT.
  - PTS_CNT = eval_len; ERR = (eval_len != N_PTS); RPT_VALID = 1.
  - Go to IDLE.
  - Report outputs hold until the next REPORT. ERR is held with them.
- Latency: DONE_IN sampled at edge E. RPT_VALID is high in the cycle following edge E + eval_len + 1 (E+41 for a full frame) and lasts exactly one cycle.
- DONE_IN while in EVAL or REPORT:
  - Ignored, with DROP=1 for the next cycle.
  - Capture bank and capture index are untouched.
- Invariants:
  - UNION_CNT <= C1_CNT + C2_CNT.
  - UNION_CNT >= max(C1_CNT, C2_CNT).
  - Accumulators never exceed N_PTS.
- BUSY = (state != IDLE), registered.

Test Plan:
- 40 points all at (5,5); DONE with C1=(5,5), C2=(0,0) -> C1_CNT=40, C2_CNT=0, UNION_CNT=40, PTS_CNT=40, ERR=0. RPT_VALID high 41 cycles after the DONE edge, for one cycle.
- Boundary: C1=(5,5); points (9,5) [sum 16] and (9,6) [sum 17]; other 38 points at (15,15); C2=(15,15) -> C1_CNT=1, C2_CNT=38, UNION_CNT=39.
- Overlap: 40 points at (4,4); C1=(4,4), C2=(6,6) [sum 8] -> C1=40, C2=40, UNION=40. Repeat with C2=(8,8) [sum 32] -> C2=0, UNION=40.
- Short/long frame: 39 points then DONE -> PTS_CNT=39, ERR=1. Then 45 points then DONE -> PTS_CNT=40, ERR=0; points 41-45 are discarded.
- Overlap/DROP: frame A DONE, then 40 points of frame B streamed during EVAL. A second DONE 10 cycles after the first -> DROP pulse, and A's report is unaffected. A later DONE evaluates B correctly with PTS_CNT=40.
- RST asserted mid-EVAL (cycle 20) -> no RPT_VALID; all outputs 0; next full frame reports correctly from bank 0.
